// File: rtl/encoder8_3_behav.sv
// Registered 8-to-3 priority encoder with enable, "any active" and "more than one active" flags.
// All outputs are flopped, so every result appears one clock after its inputs are sampled.
module encoder8_3_behav #(
    parameter bit HIGH_PRIORITY    = 1'b1,
    parameter bit CLEAR_ON_DISABLE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic Y7,
    input  logic Y6,
    input  logic Y5,
    input  logic Y4,
    input  logic Y3,
    input  logic Y2,
    input  logic Y1,
    input  logic Y0,
    output logic A2,
    output logic A1,
    output logic A0,
    output logic valid,
    output logic multi
);

    logic [7:0] req;
    logic [2:0] idx_d, idx_q;
    logic       valid_d, valid_q;
    logic       multi_d, multi_q;

    assign req = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

    function automatic logic [2:0] enc_msb_first(input logic [7:0] v);
        logic [2:0] r;
        casez (v)
            8'b1???????: r = 3'd7;
            8'b01??????: r = 3'd6;
            8'b001?????: r = 3'd5;
            8'b0001????: r = 3'd4;
            8'b00001???: r = 3'd3;
            8'b000001??: r = 3'd2;
            8'b0000001?: r = 3'd1;
            default:     r = 3'd0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] enc_lsb_first(input logic [7:0] v);
        logic [2:0] r;
        casez (v)
            8'b???????1: r = 3'd0;
            8'b??????10: r = 3'd1;
            8'b?????100: r = 3'd2;
            8'b????1000: r = 3'd3;
            8'b???10000: r = 3'd4;
            8'b??100000: r = 3'd5;
            8'b?1000000: r = 3'd6;
            8'b10000000: r = 3'd7;
            default:     r = 3'd0;
        endcase
        return r;
    endfunction

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    function automatic logic two_or_more(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        multi_d = multi_q;
        if (en) begin
            idx_d   = HIGH_PRIORITY ? enc_msb_first(req) : enc_lsb_first(req);
            valid_d = |req;
            multi_d = two_or_more(req);
        end else if (CLEAR_ON_DISABLE) begin
            idx_d   = 3'd0;
            valid_d = 1'b0;
            multi_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign {A2, A1, A0} = idx_q;
    assign valid        = valid_q;
    assign multi        = multi_q;

endmodule

// File: tb/tb_encoder8_3_behav.sv
// Scoreboard bench for encoder8_3_behav: default configuration plus the
// low-priority-first / hold-on-disable configuration, driven with the same inputs.
module tb_encoder8_3_behav;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] y_drv;

    logic a2_a, a1_a, a0_a, valid_a, multi_a;
    logic a2_b, a1_b, a0_b, valid_b, multi_b;
    logic [4:0] out_a, out_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] qa[$];
    logic [4:0] qb[$];
    logic [4:0] prev_a, prev_b;

    always #5 clk = ~clk;

    encoder8_3_behav dut_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .Y7(y_drv[7]), .Y6(y_drv[6]), .Y5(y_drv[5]), .Y4(y_drv[4]),
        .Y3(y_drv[3]), .Y2(y_drv[2]), .Y1(y_drv[1]), .Y0(y_drv[0]),
        .A2(a2_a), .A1(a1_a), .A0(a0_a), .valid(valid_a), .multi(multi_a)
    );

    encoder8_3_behav #(.HIGH_PRIORITY(1'b0), .CLEAR_ON_DISABLE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .Y7(y_drv[7]), .Y6(y_drv[6]), .Y5(y_drv[5]), .Y4(y_drv[4]),
        .Y3(y_drv[3]), .Y2(y_drv[2]), .Y1(y_drv[1]), .Y0(y_drv[0]),
        .A2(a2_b), .A1(a1_b), .A0(a0_b), .valid(valid_b), .multi(multi_b)
    );

    assign out_a = {a2_a, a1_a, a0_a, valid_a, multi_a};
    assign out_b = {a2_b, a1_b, a0_b, valid_b, multi_b};

    // Reference: count active lines, pick the first or last one seen walking upward.
    function automatic logic [4:0] ref_next(input logic [7:0] y, input bit en_v,
                                            input bit hp, input bit clr,
                                            input logic [4:0] prev);
        int cnt;
        int idx;
        logic [4:0] r;
        cnt = 0;
        idx = 0;
        if (!en_v) begin
            r = clr ? 5'd0 : prev;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (y[i]) begin
                    cnt++;
                    if (hp || cnt == 1) idx = i;
                end
            end
            r = {3'(idx), (cnt > 0), (cnt > 1)};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got {A,valid,multi}=%b required %b", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                prev_a = 5'd0;
                prev_b = 5'd0;
                qa.delete();
                qb.delete();
            end else begin
                prev_a = ref_next(y_drv, en, 1'b1, 1'b1, prev_a);
                prev_b = ref_next(y_drv, en, 1'b0, 1'b0, prev_b);
                qa.push_back(prev_a);
                qb.push_back(prev_b);
            end
        end
    end

    initial begin
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (qa.size() == 0) check("scoreboard_a_empty", out_a, 5'bxxxxx);
                else begin e = qa.pop_front(); check("scoreboard_a", out_a, e); end
                if (qb.size() == 0) check("scoreboard_b_empty", out_b, 5'bxxxxx);
                else begin e = qb.pop_front(); check("scoreboard_b", out_b, e); end
            end
        end
    end

    task automatic step(input logic e_v, input logic [7:0] y);
        @(negedge clk);
        en    = e_v;
        y_drv = y;
    endtask

    task automatic settle;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] pat;
        rst_n = 1'b0;
        en    = 1'b1;
        y_drv = 8'h80;
        #3;
        check("reset_no_edge_a", out_a, 5'b00000);
        check("reset_no_edge_b", out_b, 5'b00000);
        repeat (2) @(posedge clk);
        #2;
        check("reset_held_a", out_a, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        check("post_reset_y7", out_a, 5'b11110);

        step(1'b0, 8'h80);
        repeat (2) settle();
        check("disabled_clear", out_a, 5'b00000);
        step(1'b1, 8'h80);
        settle();
        check("reenable_y7", out_a, 5'b11110);

        for (int i = 7; i >= 0; i--) begin
            step(1'b1, 8'(1 << i));
            settle();
            check("onehot_sweep_a", out_a, {3'(i), 2'b10});
            check("onehot_sweep_b", out_b, {3'(i), 2'b10});
        end

        step(1'b1, 8'b0010_0101);
        settle();
        check("priority_multi_hp1", out_a, 5'b10111);
        check("priority_multi_hp0", out_b, 5'b00011);

        step(1'b1, 8'h00);
        settle();
        check("no_input", out_a, 5'b00000);
        step(1'b1, 8'h01);
        settle();
        check("y0_only", out_a, 5'b00010);

        step(1'b1, 8'h40);
        settle();
        check("hold_encode_y6", out_b, 5'b11010);
        step(1'b0, 8'h02);
        repeat (3) settle();
        check("hold_disabled", out_b, 5'b11010);
        check("clear_disabled", out_a, 5'b00000);

        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       pat = 8'h00;
                1:       pat = 8'(1 << $urandom_range(0, 7));
                default: pat = 8'($urandom);
            endcase
            step($urandom_range(0, 5) != 0, pat);
            if (c == 200) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("mid_reset_a", out_a, 5'b00000);
                check("mid_reset_b", out_b, 5'b00000);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        step(1'b1, 8'h00);
        repeat (2) settle();
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d/%0d entries left, required 0", qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder8_3_behav.md
Name: encoder8_3_behav

Overview:
Registered 8-to-3 priority encoder with enable. Eight discrete request lines Y7..Y0 are encoded to a 3-bit binary index A2..A1..A0. Status flags report "any input active" and "more than one input active". It sits between discrete one-hot/request sources and downstream logic that consumes a binary index. All outputs are registered, with one cycle of latency.

Parameters:
HIGH_PRIORITY, 1, 1 = Y7 has the highest priority and Y0 the lowest; 0 = Y0 highest and Y7 lowest.
CLEAR_ON_DISABLE, 1, 1 = outputs clear to 0 when en=0; 0 = outputs hold their last value when en=0.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  encoder enable, sampled on clk.
Y7  input  1  request line 7.
Y6  input  1  request line 6.
Y5  input  1  request line 5.
Y4  input  1  request line 4.
Y3  input  1  request line 3.
Y2  input  1  request line 2.
Y1  input  1  request line 1.
Y0  input  1  request line 0.
A2  output  1  encoded index, MSB.
A1  output  1  encoded index, middle bit.
A0  output  1  encoded index, LSB.
valid  output  1  1 = at least one Y line was high in the sampled cycle while enabled.
multi  output  1  1 = two or more Y lines were high in the sampled cycle while enabled.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n low, independent of clk.
- Reset values: A2=A1=A0=0, valid=0, multi=0. Outputs stay at these values while rst_n is low.
- First active update is on the first rising clk edge after rst_n deasserts.
- Latency: inputs sampled at rising edge N appear on the outputs after edge N and hold until edge N+1. No combinational path from inputs to outputs.
- en=1, HIGH_PRIORITY=1: {A2,A1,A0} = index of the highest-numbered Y line that is high. Example: Y7=1 gives 3'b111; Y3=1 alone gives 3'b011; Y0=1 alone gives 3'b000.
- en=1, HIGH_PRIORITY=0: index of the lowest-numbered Y line that is high.
- en=1 with all Y low: A=3'b000, valid=0, multi=0. valid is the only way to tell this case apart from Y0 alone.
- en=1: valid = OR of Y7..Y0.
- en=1: multi = 1 when the population count of Y7..Y0 is 2 or more. The encoded index still follows the priority rule.
- en=0, CLEAR_ON_DISABLE=1: A=3'b000, valid=0, multi=0 on the next edge, whatever the Y values are.
- en=0, CLEAR_ON_DISABLE=0: A, valid and multi hold their previous values.
- X/undefined inputs are outside the contract. Inputs are synchronous to clk and must meet setup/hold.
- Reset asserted mid-operation: outputs clear at once. No state is preserved across reset.

Test Plan:
- Reset: rst_n=0 with Y7=1, en=1 -> A=000, valid=0, multi=0 with no clock edge required. Release rst_n; the next edge gives A=111, valid=1.
- Disabled: en=0, Y7=1 for 25 ns -> A=000, valid=0. Then en=1, Y7=1 -> after one edge A=111, valid=1, multi=0.
- One-hot sweep, en=1: drive Y7..Y0 one at a time, 25 ns each -> A = 111, 110, 101, 100, 011, 010, 001, 000 in turn, each one cycle after the input. valid=1 and multi=0 throughout.
- Priority/multi: Y5=1, Y2=1, Y0=1 -> A=101, valid=1, multi=1. With HIGH_PRIORITY=0, the same input gives A=000.
- No input: en=1, all Y=0 -> A=000, valid=0, multi=0. Compare with Y0-only, which gives A=000, valid=1.
- Hold mode (CLEAR_ON_DISABLE=0): encode Y6 -> A=110. Drop en to 0 and change to Y1 -> A stays 110 and valid stays 1.
